frame_position_tracker: RTL
===========================

// Module: frame_position_tracker
// PURPOSE
//   Two-dimensional raster position counter for the filter pipeline. Generalises the
//   single-axis line-end counter: it tracks x and y and produces line-start/end and
//   frame-start/end flags, a completed-frame count and a kernel-border flag used by
//   window filters. Frame dimensions are latched into shadow registers only at frame
//   boundaries, so a dimension change never corrupts the frame in progress.
// PARAMETERS
//   X_BITS      11  width of the x counter and of the width input
//   Y_BITS      11  width of the y counter and of the height input
//   BORDER       1  kernel radius in pixels; sets the width of the border band
//   FRAME_BITS   8  width of the completed-frame counter
// PORTS
//   clock           in   1           rising-edge clock
//   reset           in   1           synchronous, active-high
//   enable          in   1           advance one pixel this cycle
//   restart         in   1           abandon the current frame; return to origin
//   width           in   X_BITS      requested pixels per line
//   height          in   Y_BITS      requested lines per frame
//   x               out  X_BITS      current column
//   y               out  Y_BITS      current row
//   is_line_start   out  1           x == 0
//   is_line_end     out  1           x == w_eff-1
//   is_frame_start  out  1           x == 0 && y == 0
//   is_frame_end    out  1           x == w_eff-1 && y == h_eff-1
//   in_border       out  1           pixel lies within BORDER of any frame edge
//   frame_count     out  FRAME_BITS  frames completed since reset; wraps modulo 2^FRAME_BITS
// BEHAVIOUR
// - Interface: reset is synchronous, active-high; clock is clock.
// - Effective dimensions: w_eff = (w_sh == 0) ? 1 : w_sh; h_eff = (h_sh == 0) ? 1 : h_sh.
// - w_sh/h_sh are the shadow copies of width/height.
// - Shadow load: w_sh <= width and h_sh <= height in any cycle with one of:
//     reset; restart; or enable && is_frame_end.
//   The frame in progress always completes with its original dimensions.
// - Priority: reset > restart > enable > hold.
// - Reset: x = 0, y = 0, frame_count = 0, shadows loaded.
//   Flags therefore reflect the new dimensions from the first cycle after reset.
// - Restart: x = 0, y = 0, shadows loaded, frame_count unchanged.
//   The enable input is ignored in the same cycle.
// - Enable, not at line end: x <= x + 1.
// - Enable at line end, not frame end: x <= 0, y <= y + 1.
// - Enable at frame end: x <= 0, y <= 0, frame_count <= frame_count + 1.
// - enable low: x, y, frame_count and shadows all hold.
// - All flags are combinational from registered state: zero latency relative to x/y.
//   Every enabled cycle is exactly one pixel; no bubbles.
// - in_border = (x < BORDER) || (x + BORDER >= w_eff)
//            || (y < BORDER) || (y + BORDER >= h_eff).
//   Compute the sums at X_BITS+1 / Y_BITS+1 bits so there is no wrap.
//   If w_eff <= 2*BORDER, every pixel is in_border.
//   BORDER = 0 forces in_border to 0.
// - Degenerate sizes:
//     w_eff = 1: is_line_start and is_line_end are both high on every pixel.
//     w_eff = 1 and h_eff = 1: is_frame_end is constantly high, and frame_count
//     increments on every enabled cycle.
// - Maximum sizes: width = 2^X_BITS-1 is supported.
//   x never exceeds w_eff-1 and never wraps through 2^X_BITS.
// - Reset or restart mid-frame: no partial-frame count; the next pixel is (0,0).
// TESTING
// - Setup: width=4, height=3, BORDER=1, enable held high.
// - T1 raster: x follows 0,1,2,3 repeating; y steps 0..2; is_line_end at x=3.
//   is_frame_end on enabled cycle 12; next cycle (0,0) with frame_count=1.
// - T2 stall: toggle enable 1,0,0,1 from (1,0).
//   Position holds at (2,0) for two cycles, then moves to (3,0); flags are stable during the stall.
// - T3 resize: width=6 written at (2,1).
//   The current frame still ends at x=3; the following frame wraps at x=5.
// - T4 border: in_border is low only at (1,1) and (2,1); it is high on the other 10 pixels.
// - T5 restart: restart with enable at (2,1).
//   Next cycle (0,0); frame_count unchanged; new width/height sampled.
// - T6 degenerate: width=0, height=1.
//   Line start, line end and frame end are all high every cycle; frame_count counts cycles.
//   Assert reset mid-frame: all outputs return to origin values next cycle.

Source files
------------

// File: rtl/frame_position_tracker_if.sv
// Interface bundling the raster-tracker control inputs and position/flag outputs.
// The master drives enable/restart/dimensions; the slave (the tracker) reports position.
interface frame_position_tracker_if #(
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 11,
    parameter int FRAME_BITS = 8
);
    logic                  enable;
    logic                  restart;
    logic [X_BITS-1:0]     width;
    logic [Y_BITS-1:0]     height;
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic                  is_line_start;
    logic                  is_line_end;
    logic                  is_frame_start;
    logic                  is_frame_end;
    logic                  in_border;
    logic [FRAME_BITS-1:0] frame_count;

    modport master (
        output enable, restart, width, height,
        input  x, y, is_line_start, is_line_end, is_frame_start, is_frame_end,
               in_border, frame_count
    );

    modport slave (
        input  enable, restart, width, height,
        output x, y, is_line_start, is_line_end, is_frame_start, is_frame_end,
               in_border, frame_count
    );
endinterface

// File: rtl/frame_position_tracker.sv
// Two-dimensional raster position counter with frame-boundary shadowed dimensions,
// line/frame flags, a completed-frame counter and a kernel-border flag.
module frame_position_tracker #(
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 11,
    parameter int BORDER     = 1,
    parameter int FRAME_BITS = 8
) (
    input  logic clock,
    input  logic reset,
    frame_position_tracker_if.slave bus
);
    localparam logic [X_BITS:0] BORDER_X = (X_BITS + 1)'(BORDER);
    localparam logic [Y_BITS:0] BORDER_Y = (Y_BITS + 1)'(BORDER);

    logic [X_BITS-1:0]     x_q, x_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    logic [X_BITS-1:0]     w_sh_q, w_sh_d;
    logic [Y_BITS-1:0]     h_sh_q, h_sh_d;
    logic [FRAME_BITS-1:0] frame_count_q, frame_count_d;

    logic [X_BITS-1:0] w_eff;
    logic [Y_BITS-1:0] h_eff;
    logic              line_end;
    logic              frame_end;
    logic              border_x;
    logic              border_y;

    // A zero dimension behaves as a single pixel so the counters always have a valid wrap point.
    always_comb begin
        w_eff     = (w_sh_q == '0) ? X_BITS'(1) : w_sh_q;
        h_eff     = (h_sh_q == '0) ? Y_BITS'(1) : h_sh_q;
        line_end  = (x_q == w_eff - X_BITS'(1));
        frame_end = line_end && (y_q == h_eff - Y_BITS'(1));
        border_x  = ({1'b0, x_q} < BORDER_X) || ({1'b0, x_q} + BORDER_X >= {1'b0, w_eff});
        border_y  = ({1'b0, y_q} < BORDER_Y) || ({1'b0, y_q} + BORDER_Y >= {1'b0, h_eff});
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        w_sh_d        = w_sh_q;
        h_sh_d        = h_sh_q;
        frame_count_d = frame_count_q;
        if (reset) begin
            x_d           = '0;
            y_d           = '0;
            w_sh_d        = bus.width;
            h_sh_d        = bus.height;
            frame_count_d = '0;
        end else if (bus.restart) begin
            x_d    = '0;
            y_d    = '0;
            w_sh_d = bus.width;
            h_sh_d = bus.height;
        end else if (bus.enable) begin
            if (frame_end) begin
                // Dimensions change only here, so a frame always finishes with its own size.
                x_d           = '0;
                y_d           = '0;
                w_sh_d        = bus.width;
                h_sh_d        = bus.height;
                frame_count_d = frame_count_q + FRAME_BITS'(1);
            end else if (line_end) begin
                x_d = '0;
                y_d = y_q + Y_BITS'(1);
            end else begin
                x_d = x_q + X_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        x_q           <= x_d;
        y_q           <= y_d;
        w_sh_q        <= w_sh_d;
        h_sh_q        <= h_sh_d;
        frame_count_q <= frame_count_d;
    end

    assign bus.x              = x_q;
    assign bus.y              = y_q;
    assign bus.is_line_start  = (x_q == '0);
    assign bus.is_line_end    = line_end;
    assign bus.is_frame_start = (x_q == '0) && (y_q == '0);
    assign bus.is_frame_end   = frame_end;
    assign bus.in_border      = (BORDER != 0) && (border_x || border_y);
    assign bus.frame_count    = frame_count_q;
endmodule
